pkt_cache_tx: RTL
=================

# pkt_cache_tx

Receive side of the data-cache output bus. Accepts the 134-bit word stream and the end-of-packet valid strobe produced by the packet-RAM read controller and buffers the words in a local word FIFO. It commits or drops each packet whole, then retransmits committed packets on the packet bus with regenerated framing tags, subject to downstream almost-full backpressure. It sits between the packet-RAM read controller and the egress port logic.

## Interface
- DEPTH_LOG2, 8, word FIFO depth is 2^DEPTH_LOG2 words of 134 bits.
- LENQ_LOG2, 4, packet-length queue depth is 2^LENQ_LOG2 entries.
- MAX_PKT_WORDS, 32, largest legal packet in words; used for cache_alf.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_cache_data  in  134  data word; [133:132] tag, [131:128] valid-byte field, [127:0] payload.
- in_cache_data_wr  in  1  in_cache_data is valid this cycle.
- in_cache_valid  in  1  packet-complete indication.
- in_cache_valid_wr  in  1  qualifier for in_cache_valid.
- out_pkt_data  out  134  transmitted word with regenerated tag.
- out_pkt_data_wr  out  1  out_pkt_data is valid.
- in_pkt_alf  in  1  downstream almost full.
- cache_alf  out  1  upstream must not start a new packet read.
- drop_cnt  out  16  count of dropped packets; saturates at 16'hFFFF.

## Operation
- Write side:
  - Each in_cache_data_wr writes in_cache_data to wptr and increments wptr and cur_len (9-bit).
  - A word arriving while the FIFO is full is not written, and the pkt_bad flag is set.
  - Pointers are DEPTH_LOG2+1 bits. used = wptr - rptr, modulo arithmetic.
  - Full is evaluated on the registered used count, so a read that frees a slot in the same cycle does not rescue the word.
- Commit happens when in_cache_valid_wr and in_cache_valid are both high.
  - A data word presented in the same cycle belongs to the packet being committed.
  - Good packet: push cur_len into the length queue and set pkt_start to wptr.
  - Drop condition: pkt_bad, or cur_len == 0, or cur_len > MAX_PKT_WORDS, or the length queue is full.
  - On drop: wptr rolls back to pkt_start, drop_cnt increments (saturating), and nothing is pushed.
  - In both cases cur_len and pkt_bad clear.
- Read FSM:
  - TX_IDLE: when the length queue is non-empty and in_pkt_alf == 0, pop the length into rem and go to TX_RD.
  - TX_RD: issue one RAM read per cycle at rptr, increment rptr, decrement rem. When rem reaches 1, issue the last read and go to TX_GAP.
  - TX_GAP: one cycle with no reads, then TX_IDLE.
  - in_pkt_alf is sampled only in TX_IDLE; a packet, once started, is sent without stalls.
- Output tags, by word index within the packet:
  - Last word: 2'b10. This includes a single-word packet.
  - Otherwise first word: 2'b01.
  - All remaining words: 2'b11.
  - Bits [131:0] pass through unchanged.
- cache_alf = (2^DEPTH_LOG2 - used < MAX_PKT_WORDS) OR (length queue has at most one free entry). It is registered.
- Simultaneous push and pop on the length queue are both honoured, and the count is unchanged.

## Timing
- Reset values:
  - out_pkt_data = 0, out_pkt_data_wr = 0, cache_alf = 0, drop_cnt = 0.
  - FSM in TX_IDLE.
  - Pointers, cur_len, pkt_bad and the length queue cleared.
- Reset mid-packet discards all buffered and partial data.
- RAM read latency: 1 cycle. Output is registered.
- With T the TX_IDLE decision cycle, the first read issues at T+1 and the first out_pkt_data_wr is at T+3. An N-word packet then has N consecutive out_pkt_data_wr cycles.
- A committed packet is visible to TX_IDLE the cycle after commit.
- Minimum gap between output packets: 2 idle cycles (TX_GAP plus TX_IDLE).
- The write and read sides run concurrently. A packet may be read while the next packet is still being written.

## Test plan
- Single packet: 4 words, commit on the 4th word -> out_pkt_data_wr high 4 consecutive cycles, tags 01, 11, 11, 10, payload bit-exact, first word 3 cycles after the TX_IDLE decision.
- Single-word packet: 1 word with the valid strobe in the same cycle -> one output word, tag 10. Valid strobe with no words -> drop_cnt = 1, no output.
- Backpressure: hold in_pkt_alf = 1 and commit 3 packets -> no output. Release -> 3 packets back-to-back with 2-cycle gaps; in_pkt_alf asserted mid-packet does not stall it.
- Overflow, DEPTH_LOG2 = 5 with the read side blocked: fill 30 words, then send a 4-word packet -> dropped, drop_cnt increments, wptr restored. The following 2-word packet is accepted and sent intact.
- cache_alf, DEPTH_LOG2 = 6, MAX_PKT_WORDS = 32: 33 used words -> cache_alf = 1; drain to 32 used -> cache_alf = 0 one cycle later. Also assert when the length queue has 15 of 16 entries used.
- Reset asserted mid-transmission -> out_pkt_data_wr = 0 immediately, drop_cnt = 0. The next packet after release is transmitted correctly.

Source files
------------

// File: rtl/pkt_cache_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_cache_tx_if
//  Description : Bus bundle for pkt_cache_tx. Carries the data-cache word
//                stream and packet-complete strobe coming from the packet-RAM
//                read controller, the regenerated packet bus going to egress,
//                and the backpressure / status lines between them.
//  Signals     : in_cache_data[133:0]  cache word ([133:132] tag, [131:128]
//                                      valid-byte field, [127:0] payload)
//                in_cache_data_wr      in_cache_data is valid
//                in_cache_valid        packet-complete indication
//                in_cache_valid_wr     qualifier for in_cache_valid
//                out_pkt_data[133:0]   transmitted word with regenerated tag
//                out_pkt_data_wr       out_pkt_data is valid
//                in_pkt_alf            downstream almost full
//                cache_alf             upstream must not start a new packet
//                drop_cnt[15:0]        saturating dropped-packet count
//  Modports    : slave  - view of pkt_cache_tx
//                master - view of the surrounding logic
//  Revision    : 1.0  initial release
// ============================================================================
interface pkt_cache_tx_if;

    logic [133:0] in_cache_data;
    logic         in_cache_data_wr;
    logic         in_cache_valid;
    logic         in_cache_valid_wr;
    logic [133:0] out_pkt_data;
    logic         out_pkt_data_wr;
    logic         in_pkt_alf;
    logic         cache_alf;
    logic [15:0]  drop_cnt;

    modport slave (
        input  in_cache_data,
        input  in_cache_data_wr,
        input  in_cache_valid,
        input  in_cache_valid_wr,
        input  in_pkt_alf,
        output out_pkt_data,
        output out_pkt_data_wr,
        output cache_alf,
        output drop_cnt
    );

    modport master (
        output in_cache_data,
        output in_cache_data_wr,
        output in_cache_valid,
        output in_cache_valid_wr,
        output in_pkt_alf,
        input  out_pkt_data,
        input  out_pkt_data_wr,
        input  cache_alf,
        input  drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pkt_cache_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_cache_tx
//  Description : Receive side of the data-cache output bus. Buffers incoming
//                134-bit words in a local word FIFO, commits or drops each
//                packet as a whole when its packet-complete strobe arrives,
//                and retransmits committed packets on the packet bus with
//                regenerated framing tags (01 first, 11 middle, 10 last),
//                honouring downstream almost-full between packets.
//  Ports       : clk    clock
//                rst_n  asynchronous active-low reset
//                bus    pkt_cache_tx_if.slave (cache input stream, packet
//                       output stream, in_pkt_alf, cache_alf, drop_cnt)
//  Parameters  : DEPTH_LOG2     word FIFO depth is 2^DEPTH_LOG2 words
//                LENQ_LOG2      length queue depth is 2^LENQ_LOG2 entries
//                MAX_PKT_WORDS  largest legal packet, in words
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_cache_tx #(
    parameter int DEPTH_LOG2    = 8,
    parameter int LENQ_LOG2     = 4,
    parameter int MAX_PKT_WORDS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_cache_tx_if.slave bus
);

    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int LENQ_DEPTH = 1 << LENQ_LOG2;

    localparam logic [DEPTH_LOG2:0] FIFO_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [LENQ_LOG2:0]  LENQ_FULL  = (LENQ_LOG2 + 1)'(LENQ_DEPTH);
    localparam logic [31:0]         DEPTH_W    = 32'(DEPTH);
    localparam logic [31:0]         LENQ_W     = 32'(LENQ_DEPTH);
    localparam logic [31:0]         MAX_WORDS  = 32'(MAX_PKT_WORDS);

    localparam logic [1:0] TAG_FIRST = 2'b01;
    localparam logic [1:0] TAG_MID   = 2'b11;
    localparam logic [1:0] TAG_LAST  = 2'b10;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_RD   = 2'd1;
    localparam logic [1:0] TX_GAP  = 2'd2;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [133:0] mem  [DEPTH];
    logic [8:0]   lenq [LENQ_DEPTH];

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic [DEPTH_LOG2:0] r_pkt_start;
    logic [8:0]          r_cur_len;
    logic                r_pkt_bad;
    logic [15:0]         r_drop_cnt;

    logic [LENQ_LOG2:0]  r_lq_wptr;
    logic [LENQ_LOG2:0]  r_lq_rptr;

    // ------------------------------------------------------------------
    // Read-side state
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [8:0]          r_rem;
    logic                r_first;
    logic                r_rd_vld;
    logic [1:0]          r_rd_tag;
    logic [131:0]        r_rd_word;
    logic [133:0]        r_out_data;
    logic                r_out_wr;
    logic                r_cache_alf;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2:0] w_used;
    logic                w_fifo_full;
    logic                w_wr_fire;
    logic                w_wr_bad;
    logic [DEPTH_LOG2:0] w_wptr_nxt;
    logic                w_commit;
    logic [8:0]          w_len_eff;
    logic                w_bad_eff;
    logic                w_too_long;
    logic                w_drop;
    logic                w_push;
    logic [LENQ_LOG2:0]  w_lq_count;
    logic                w_lq_full;
    logic                w_lq_empty;
    logic [8:0]          w_lq_head;
    logic                w_pop;
    logic                w_rd_en;
    logic [1:0]          w_rd_tag;
    logic [31:0]         w_free_words;
    logic                w_alf_nxt;
    logic                w_unused_tag;

    // Incoming tags are regenerated on output, so they are never stored.
    assign w_unused_tag = ^bus.in_cache_data[133:132];

    // Full is taken from the registered pointers: a read freeing a slot in
    // the same cycle does not make room for the arriving word.
    assign w_used      = r_wptr - r_rptr;
    assign w_fifo_full = (w_used == FIFO_FULL);
    assign w_wr_fire   = bus.in_cache_data_wr && !w_fifo_full;
    assign w_wr_bad    = bus.in_cache_data_wr &&  w_fifo_full;
    assign w_wptr_nxt  = w_wr_fire ? r_wptr + 1'b1 : r_wptr;

    // A word presented alongside the commit strobe belongs to the packet
    // being committed, so length and bad flag include this cycle's word.
    // The length saturates so an oversized stream can never wrap to a
    // plausible small value.
    assign w_commit   = bus.in_cache_valid_wr && bus.in_cache_valid;
    assign w_len_eff  = (bus.in_cache_data_wr && (r_cur_len != 9'h1FF))
                        ? r_cur_len + 9'd1 : r_cur_len;
    assign w_bad_eff  = r_pkt_bad || w_wr_bad;
    assign w_too_long = (32'(w_len_eff) > MAX_WORDS);

    assign w_lq_count = r_lq_wptr - r_lq_rptr;
    assign w_lq_full  = (w_lq_count == LENQ_FULL);
    assign w_lq_empty = (w_lq_count == '0);
    assign w_lq_head  = lenq[r_lq_rptr[LENQ_LOG2-1:0]];

    assign w_drop = w_commit &&
                    (w_bad_eff || (w_len_eff == 9'd0) || w_too_long || w_lq_full);
    assign w_push = w_commit && !w_drop;

    // Downstream backpressure only gates the start of a packet.
    assign w_pop   = (r_state == TX_IDLE) && !w_lq_empty && !bus.in_pkt_alf;
    assign w_rd_en = (r_state == TX_RD);

    // Last takes priority so a single-word packet is tagged as last.
    always_comb begin
        w_rd_tag = TAG_MID;
        if (r_rem == 9'd1) begin
            w_rd_tag = TAG_LAST;
        end else if (r_first) begin
            w_rd_tag = TAG_FIRST;
        end
    end

    // Upstream must hold off while a maximum-size packet might not fit, or
    // while the length queue could not take two more packets.
    assign w_free_words = DEPTH_W - 32'(w_used);
    assign w_alf_nxt    = (w_free_words < MAX_WORDS) ||
                          (32'(w_lq_count) >= (LENQ_W - 32'd1));

    // ------------------------------------------------------------------
    // Memories (no reset; contents are only read behind valid pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.in_cache_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            lenq[r_lq_wptr[LENQ_LOG2-1:0]] <= w_len_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_rd_word <= mem[r_rptr[DEPTH_LOG2-1:0]][131:0];
        end
    end

    // ------------------------------------------------------------------
    // Write side: packet assembly, commit and drop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_pkt_start <= '0;
            r_cur_len   <= '0;
            r_pkt_bad   <= 1'b0;
            r_drop_cnt  <= '0;
            r_lq_wptr   <= '0;
        end else if (w_commit) begin
            r_cur_len <= '0;
            r_pkt_bad <= 1'b0;
            if (w_drop) begin
                // Discard everything written since the last good commit.
                r_wptr <= r_pkt_start;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else begin
                r_wptr      <= w_wptr_nxt;
                r_pkt_start <= w_wptr_nxt;
                r_lq_wptr   <= r_lq_wptr + 1'b1;
            end
        end else begin
            r_wptr    <= w_wptr_nxt;
            r_cur_len <= w_len_eff;
            r_pkt_bad <= w_bad_eff;
        end
    end

    // ------------------------------------------------------------------
    // Read side: transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_rptr    <= '0;
            r_lq_rptr <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_rem     <= w_lq_head;
                        r_first   <= 1'b1;
                        r_lq_rptr <= r_lq_rptr + 1'b1;
                        r_state   <= TX_RD;
                    end
                end
                TX_RD: begin
                    r_rptr  <= r_rptr + 1'b1;
                    r_rem   <= r_rem - 9'd1;
                    r_first <= 1'b0;
                    if (r_rem == 9'd1) begin
                        r_state <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    r_state <= TX_IDLE;
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld    <= 1'b0;
            r_rd_tag    <= '0;
            r_out_data  <= '0;
            r_out_wr    <= 1'b0;
            r_cache_alf <= 1'b0;
        end else begin
            r_rd_vld    <= w_rd_en;
            r_rd_tag    <= w_rd_tag;
            r_out_wr    <= r_rd_vld;
            r_cache_alf <= w_alf_nxt;
            if (r_rd_vld) begin
                r_out_data <= {r_rd_tag, r_rd_word};
            end
        end
    end

    assign bus.out_pkt_data    = r_out_data;
    assign bus.out_pkt_data_wr = r_out_wr;
    assign bus.cache_alf       = r_cache_alf;
    assign bus.drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire
